savestates_regs_seq: RTL and testbench

- Sequencer directly upstream of the save-state shadow-register block.
- Walks a fixed list of shadow-register addresses in bank $C0 and drives ca, ss_reg_sel and cpuwr_ce on that block.
- Save: captures ssr_do into 64-bit words and streams them to the save-state memory writer.
- Load: takes 64-bit words from the memory reader and writes them back byte-by-byte.

---
 rtl/savestates_pkg.sv | 13 +
 rtl/savestates_regs_seq_word_pack.sv | 55 +++++
 rtl/savestates_regs_seq.sv | 105 ++++++++++
 tb/tb_savestates_regs_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/savestates_pkg.sv
// savestates_pkg: FSM states, list sizes and shadow-register address list for the save-state sequencer
package savestates_pkg;
  localparam int SS_LIST_LEN = 31;
  localparam int SS_WORDS = 4;
  typedef enum logic [3:0] {IDLE, S_ADDR, S_WAIT, S_CAPT, S_PUSH, L_PULL, L_WRITE, L_GAP, DONE} state_e;
  function automatic logic [15:0] ss_addr(input logic [4:0] idx);
    ss_addr = idx < 5'd16 ? 16'h4200 + 16'(idx) :
              idx < 5'd20 ? 16'h2180 + 16'(idx - 5'd16) :
              idx == 5'd20 ? 16'h2100 :
              idx < 5'd24 ? 16'h21F0 + 16'(idx - 5'd21) :
              16'h4300 + 16'(idx - 5'd24);
  endfunction
endpackage

// File: rtl/savestates_regs_seq_word_pack.sv
// savestates_word_pack: 64-bit word lane insert/extract and running byte checksum (SS_REGS_CSUM_EN enables checksum pad/check)
module savestates_word_pack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        csum_clr_i,
  input  logic        ins_i,
  input  logic        pad_i,
  input  logic        ld_i,
  input  logic [2:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic [63:0] word_i,
  output logic [63:0] word_o,
  output logic [7:0]  lane_o,
  output logic        csum_bad_o
);
  logic [63:0] word_q, word_d;
  logic [7:0] csum_q, csum_d, word_sum, pad_byte;
`ifdef SS_REGS_CSUM_EN
  assign pad_byte = 8'h00 - csum_q - byte_i;
  assign csum_bad_o = |csum_q;
`else
  assign pad_byte = 8'h00;
  assign csum_bad_o = 1'b0;
`endif
  assign word_o = word_q;
  assign lane_o = word_q[{lane_i, 3'b000} +: 8];
  // Byte sum of an incoming load word, folded into the checksum in one step
  always_comb begin
    word_sum = 8'h00;
    for (int i = 0; i < 8; i++) word_sum = word_sum + word_i[8*i +: 8];
  end
  // Next word/checksum: whole-word load, or single-lane insert with optional pad lane
  always_comb begin
    word_d = word_q;
    csum_d = csum_clr_i ? 8'h00 : csum_q;
    if (ld_i) begin
      word_d = word_i;
      csum_d = csum_q + word_sum;
    end else if (ins_i) begin
      word_d[{lane_i, 3'b000} +: 8] = byte_i;
      csum_d = csum_q + byte_i;
      if (pad_i) word_d[63:56] = pad_byte;
    end
  end
  // Word and checksum registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q <= '0;
      csum_q <= '0;
    end else begin
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end
endmodule

// File: rtl/savestates_regs_seq.sv
// savestates_regs_seq: save/load sequencer for the $C0 shadow-register block (SS_REGS_CSUM_EN adds checksum byte)
module savestates_regs_seq
  import savestates_pkg::*;
#(
  parameter logic [7:0] SS_BANK = 8'hC0,
  parameter int NUM_BYTES = SS_LIST_LEN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_save,
  input  logic        start_load,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] ca,
  output logic        ss_reg_sel,
  output logic        cpuwr_ce,
  output logic [7:0]  di,
  input  logic [7:0]  ssr_do,
  input  logic        ssr_oe,
  output logic [63:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  input  logic [63:0] rd_data,
  input  logic        rd_valid,
  output logic        rd_ready
);
  localparam logic [4:0] LAST = 5'(NUM_BYTES - 1);
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic err_q, err_d, ins, ld, csum_clr, csum_bad, lane7, last;
  logic [23:0] ca_q, ca_d;
  logic [7:0] lane_byte;
  assign lane7 = &idx_q[2:0];
  assign last = idx_q == LAST;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign ca = ca_q;
  assign ss_reg_sel = busy;
  assign cpuwr_ce = state_q == L_WRITE;
  assign di = cpuwr_ce ? lane_byte : 8'h00;
  assign wr_valid = state_q == S_PUSH;
  assign rd_ready = state_q == L_PULL;
  savestates_word_pack u_pack (
    .clk(clk), .reset_n(reset_n), .csum_clr_i(csum_clr), .ins_i(ins), .pad_i(last), .ld_i(ld),
    .lane_i(idx_q[2:0]), .byte_i(ssr_do), .word_i(rd_data), .word_o(wr_data), .lane_o(lane_byte),
    .csum_bad_o(csum_bad)
  );
  // Next-state, index, error and address logic
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    ins = 1'b0;
    ld = 1'b0;
    csum_clr = 1'b0;
    case (state_q)
      IDLE: if (start_save || start_load) begin
        state_d = start_save ? S_ADDR : L_PULL;
        idx_d = '0;
        err_d = 1'b0;
        csum_clr = 1'b1;
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        ins = 1'b1;
        err_d = err_q | ~ssr_oe;
        state_d = (lane7 || last) ? S_PUSH : S_ADDR;
        idx_d = (lane7 || last) ? idx_q : idx_q + 5'd1;
      end
      S_PUSH: if (wr_ready) begin
        state_d = last ? DONE : S_ADDR;
        idx_d = last ? idx_q : idx_q + 5'd1;
      end
      L_PULL: if (rd_valid) begin
        ld = 1'b1;
        state_d = L_WRITE;
      end
      L_WRITE: state_d = L_GAP;
      L_GAP: begin
        state_d = last ? DONE : lane7 ? L_PULL : L_WRITE;
        idx_d = last ? idx_q : idx_q + 5'd1;
        err_d = err_q | (last & csum_bad);
      end
      default: state_d = IDLE;
    endcase
    ca_d = (state_d == S_ADDR || state_d == L_WRITE) ? {SS_BANK, ss_addr(idx_d)} : ca_q;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= 1'b0;
      ca_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      ca_q <= ca_d;
    end
  end
endmodule

// File: tb/tb_savestates_regs_seq.sv
// tb_savestates_regs_seq: directed self-checking bench for the save-state register sequencer
module tb_savestates_regs_seq;
  logic clk = 0, reset_n = 0, start_save = 0, start_load = 0, wr_ready = 0, rd_valid = 0, kill_oe = 0;
  logic ssr_oe = 1;
  logic [7:0] ssr_do = 0;
  logic busy, done, err, ss_reg_sel, cpuwr_ce, wr_valid, rd_ready;
  logic [23:0] ca;
  logic [7:0] di;
  logic [63:0] wr_data, rd_data;
  logic [63:0] rd_base = 0, rd_last = 0;
  int checks = 0, errors = 0, cyc = 0, nwr = 0, nce = 0, nrd = 0, ndone = 0, multi = 0, last_hs = 0, done_cyc = 0;
  logic err_at_done = 0, ce_prev = 0;
  logic [63:0] wr_log [64];
  logic [23:0] ce_ca [128];
  logic [7:0] ce_di [128];
  logic [63:0] exp_w [4];
  int dn = 0, base = 0, ce0 = 0, nrd0 = 0;
  logic csum_on;
  logic stable;
  logic [63:0] hold_d;
  logic [23:0] hold_a;

  savestates_regs_seq dut (
    .clk(clk), .reset_n(reset_n), .start_save(start_save), .start_load(start_load), .busy(busy), .done(done),
    .err(err), .ca(ca), .ss_reg_sel(ss_reg_sel), .cpuwr_ce(cpuwr_ce), .di(di), .ssr_do(ssr_do), .ssr_oe(ssr_oe),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready)
  );

  assign rd_data = (nrd - nrd0 >= 3) ? rd_last : rd_base;

  always #5 clk = ~clk;

  // Shadow-register block model: read data is the low address byte, one cycle late
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ssr_do <= ca[7:0];
    ssr_oe <= !(kill_oe && ca[15:0] == 16'h2100);
    if (rd_valid && rd_ready) nrd <= nrd + 1;
  end

  // Recorders for handshakes, write strobes and done pulses
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      wr_log[nwr] <= wr_data;
      nwr <= nwr + 1;
      last_hs <= cyc;
    end
    if (cpuwr_ce) begin
      ce_ca[nce] <= ca;
      ce_di[nce] <= di;
      nce <= nce + 1;
      if (ce_prev) multi <= multi + 1;
    end
    ce_prev <= cpuwr_ce;
    if (done) begin
      ndone <= ndone + 1;
      err_at_done <= err;
      done_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic go(input logic save);
    if (save) start_save = 1;
    else start_load = 1;
    tick(1);
    start_save = 0;
    start_load = 0;
  endtask

  task automatic wait_done();
    dn++;
    for (int i = 0; i < 600 && ndone < dn; i++) tick(1);
    chk("done_seen", 64'(ndone >= dn), 64'd1);
    tick(1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 300 && nwr - base < n; i++) tick(1);
    chk("word_count_wait", 64'(nwr - base >= n), 64'd1);
  endtask

  task automatic wait_push();
    for (int i = 0; i < 300 && !wr_valid; i++) tick(1);
    chk("push_wait", 64'(wr_valid), 64'd1);
  endtask

  task automatic check_save(input string tag);
    chk({tag, "_nwords"}, 64'(nwr - base), 64'd4);
    for (int k = 0; k < 4; k++) chk({tag, "_word"}, wr_log[base + k], exp_w[k]);
  endtask

  initial begin
`ifdef SS_REGS_CSUM_EN
    csum_on = 1;
    exp_w = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'hF2F1F00083828180, 64'h9A06050403020100};
`else
    csum_on = 0;
    exp_w = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'hF2F1F00083828180, 64'h0006050403020100};
`endif
    tick(3);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_ca", 64'(ca), 0);
    chk("rst_sel", 64'(ss_reg_sel), 0);
    chk("rst_ce", 64'(cpuwr_ce), 0);
    chk("rst_di", 64'(di), 0);
    chk("rst_wr_valid", 64'(wr_valid), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_ready", 64'(rd_ready), 0);
    reset_n = 1;
    wr_ready = 1;
    tick(2);
    base = nwr;
    go(1);
    chk("save_busy", 64'(busy), 1);
    chk("save_sel", 64'(ss_reg_sel), 1);
    chk("save_first_ca", 64'(ca), 64'hC04200);
    wait_done();
    check_save("save1");
    chk("save1_err", 64'(err_at_done), 0);
    chk("save1_done_lat", 64'(done_cyc), 64'(last_hs + 1));
    chk("save1_idle", 64'(busy), 0);
    base = nwr;
    go(1);
    wait_words(1);
    wr_ready = 0;
    wait_push();
    hold_d = wr_data;
    hold_a = ca;
    stable = 1;
    repeat (20) begin
      tick(1);
      if (!wr_valid || wr_data !== hold_d || ca !== hold_a) stable = 0;
    end
    chk("stall_stable", 64'(stable), 1);
    chk("stall_word", hold_d, exp_w[1]);
    chk("stall_ca", 64'(hold_a), 64'hC0420F);
    wr_ready = 1;
    wait_done();
    check_save("stall");
    kill_oe = 1;
    base = nwr;
    go(1);
    wait_done();
    kill_oe = 0;
    chk("oe_err", 64'(err_at_done), 1);
    chk("oe_nwords", 64'(nwr - base), 4);
    chk("oe_err_sticky", 64'(err), 1);
    rd_base = 64'h1122334455667788;
    rd_last = 64'h1122334455667788;
    nrd0 = nrd;
    ce0 = nce;
    rd_valid = 1;
    go(0);
    chk("load_err_cleared", 64'(err), 0);
    wait_done();
    rd_valid = 0;
    chk("load_nce", 64'(nce - ce0), 31);
    chk("load_single_ce", 64'(multi), 0);
    chk("load_nwords", 64'(nrd - nrd0), 4);
    chk("load_w0_ca", 64'(ce_ca[ce0]), 64'hC04200);
    chk("load_w0_di", 64'(ce_di[ce0]), 64'h88);
    chk("load_w16_ca", 64'(ce_ca[ce0 + 16]), 64'hC02180);
    chk("load_w16_di", 64'(ce_di[ce0 + 16]), 64'h88);
    chk("load_w20_ca", 64'(ce_ca[ce0 + 20]), 64'hC02100);
    chk("load_w20_di", 64'(ce_di[ce0 + 20]), 64'h44);
    chk("load_w30_ca", 64'(ce_ca[ce0 + 30]), 64'hC04306);
    chk("load_w30_di", 64'(ce_di[ce0 + 30]), 64'h22);
    chk("load_err", 64'(err_at_done), 64'(csum_on));
    base = nwr;
    go(1);
    wait_words(2);
    wr_ready = 0;
    wait_push();
    reset_n = 0;
    tick(1);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_wr_valid", 64'(wr_valid), 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_ca", 64'(ca), 0);
    chk("mid_rst_sel", 64'(ss_reg_sel), 0);
    chk("mid_rst_nwords", 64'(nwr - base), 2);
    reset_n = 1;
    wr_ready = 1;
    tick(1);
    base = nwr;
    go(1);
    wait_done();
    check_save("after_rst");
    chk("after_rst_err", 64'(err_at_done), 0);
`ifdef SS_REGS_CSUM_EN
    rd_base = 0;
    rd_last = 0;
    nrd0 = nrd;
    rd_valid = 1;
    go(0);
    wait_done();
    chk("csum_ok_err", 64'(err_at_done), 0);
    rd_last = 64'h0100000000000000;
    nrd0 = nrd;
    go(0);
    wait_done();
    rd_valid = 0;
    chk("csum_bad_err", 64'(err_at_done), 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
